// File: rtl/reversi_pkg.sv
// Shared definitions for the reversi move checker: board geometry, cell codes,
// FSM state encoding, the per-direction step table and a population-count helper.
package reversi_pkg;

    localparam int CELLS   = 64;
    localparam int CELL_W  = 3;
    localparam int BOARD_W = CELLS * CELL_W;
    localparam int POS_W   = 6;
    localparam int INDEX_W = 7;
    localparam int DIR_W   = 3;
    localparam int COUNT_W = 5;

    // Cell codes: any code with the top bit clear is an empty square.
    localparam logic [CELL_W-1:0] CELL_EMPTY = 3'b000;
    localparam logic [CELL_W-1:0] CELL_BLACK = 3'b111;
    localparam logic [CELL_W-1:0] CELL_WHITE = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WALK  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Directions are walked in this order: N, NE, E, SE, S, SW, W, NW.
    localparam logic [DIR_W-1:0] DIR_LAST = 3'd7;

    localparam logic signed [4:0] DIR_DELTA [8] = '{
        -5'sd8, -5'sd7, 5'sd1, 5'sd9, 5'sd8, 5'sd7, -5'sd1, -5'sd9
    };

    // Which directions move towards each board edge (bit n = direction n).
    localparam logic [7:0] DIR_UP    = 8'b1000_0011;
    localparam logic [7:0] DIR_DOWN  = 8'b0011_1000;
    localparam logic [7:0] DIR_RIGHT = 8'b0000_1110;
    localparam logic [7:0] DIR_LEFT  = 8'b1110_0000;

    // Number of set bits in a cell mask; a single move can flip at most 18 discs.
    function automatic logic [COUNT_W-1:0] popcount(input logic [CELLS-1:0] m);
        logic [COUNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CELLS; i++) begin
            cnt = cnt + COUNT_W'(m[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/board_step.sv
// One step across the 8x8 board: given a cell and a direction, returns the
// neighbouring cell and whether that step would leave the board (row or column
// bound), so column wrap such as cell 7 -> cell 8 is reported as off-board.
module board_step
    import reversi_pkg::*;
(
    input  logic [POS_W-1:0] i_cell,
    input  logic [DIR_W-1:0] i_dir,
    output logic [POS_W-1:0] o_next_cell,
    output logic             o_off_board
);

    logic [2:0]       w_row;
    logic [2:0]       w_col;
    logic [POS_W-1:0] w_delta;

    assign w_row   = i_cell[5:3];
    assign w_col   = i_cell[2:0];
    assign w_delta = POS_W'(DIR_DELTA[i_dir]);

    // Modulo-64 add; only meaningful when o_off_board is low.
    assign o_next_cell = i_cell + w_delta;

    assign o_off_board = (DIR_UP[i_dir]    && (w_row == 3'd0)) ||
                         (DIR_DOWN[i_dir]  && (w_row == 3'd7)) ||
                         (DIR_LEFT[i_dir]  && (w_col == 3'd0)) ||
                         (DIR_RIGHT[i_dir] && (w_col == 3'd7));

endmodule

// File: rtl/move_check.sv
// Reversi move checker: on start, captures a board, a target cell and the side
// to move, then walks the eight directions one cell per cycle and reports which
// opponent discs the move would flip.
module move_check #(
    parameter int CELLS  = reversi_pkg::CELLS,
    parameter int CELL_W = reversi_pkg::CELL_W
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              start,
    input  logic [CELLS*CELL_W-1:0]           curr_board,
    input  logic [reversi_pkg::INDEX_W-1:0]   index,
    input  logic                              player_black,
    output logic                              busy,
    output logic                              done,
    output logic                              legal,
    output logic [CELLS-1:0]                  flip_mask,
    output logic [reversi_pkg::COUNT_W-1:0]   flip_count
);

    import reversi_pkg::*;

    localparam logic [CELLS-1:0] MASK_LSB = CELLS'(1);

    state_t                    r_state;
    state_t                    w_state_next;

    logic [CELLS*CELL_W-1:0]   r_board;
    logic [INDEX_W-1:0]        r_index;
    logic                      r_player;

    logic [POS_W-1:0]          r_target;
    logic [POS_W-1:0]          r_ptr;
    logic [DIR_W-1:0]          r_dir;
    logic [CELLS-1:0]          r_run;
    logic [CELLS-1:0]          r_acc;

    logic [CELLS-1:0]          r_flip_mask;
    logic                      r_legal;
    logic [COUNT_W-1:0]        r_flip_count;

    logic [POS_W-1:0]          w_ptr_next;
    logic [DIR_W-1:0]          w_dir_next;
    logic [CELLS-1:0]          w_run_next;
    logic [CELLS-1:0]          w_acc_next;
    logic                      w_accept;
    logic                      w_dir_end;

    logic [INDEX_W-1:0]        w_cell_num;
    logic [INDEX_W-1:0]        w_index_rem;
    logic [CELL_W-1:0]         w_target_code;
    logic                      w_target_bad;

    logic [CELL_W-1:0]         w_own;
    logic [CELL_W-1:0]         w_opp;

    logic [POS_W-1:0]          w_step_cell;
    logic                      w_step_off;
    logic [CELL_W-1:0]         w_walk_code;
    logic [POS_W-1:0]          w_unused_look_cell;
    logic                      w_look_off;

    // Target decode from the captured index: cell = index/3, must be aligned,
    // on the board and empty.
    assign w_cell_num    = r_index / INDEX_W'(3);
    assign w_index_rem   = r_index % INDEX_W'(3);
    assign w_target_code = r_board[int'(w_cell_num) * CELL_W +: CELL_W];
    assign w_target_bad  = (w_index_rem != '0) ||
                           (w_cell_num >= INDEX_W'(CELLS)) ||
                           w_target_code[CELL_W-1];

    assign w_own = r_player ? CELL_BLACK : CELL_WHITE;
    assign w_opp = r_player ? CELL_WHITE : CELL_BLACK;

    // The cell read this cycle.
    board_step u_step (
        .i_cell      (r_ptr),
        .i_dir       (r_dir),
        .o_next_cell (w_step_cell),
        .o_off_board (w_step_off)
    );

    // One step further: an opponent run that reaches the edge can never be
    // bracketed, so the direction ends now and each direction costs at most
    // seven cycles.
    board_step u_look (
        .i_cell      (w_step_cell),
        .i_dir       (r_dir),
        .o_next_cell (w_unused_look_cell),
        .o_off_board (w_look_off)
    );

    assign w_walk_code = r_board[int'(w_step_cell) * CELL_W +: CELL_W];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the walk datapath updates.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_dir_next   = r_dir;
        w_run_next   = r_run;
        w_acc_next   = r_acc;
        w_accept     = 1'b0;
        w_dir_end    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_CHECK;
                    w_run_next   = '0;
                    w_acc_next   = '0;
                end
            end

            ST_CHECK: begin
                if (w_target_bad) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_WALK;
                    w_dir_next   = '0;
                    w_ptr_next   = w_cell_num[POS_W-1:0];
                    w_run_next   = '0;
                end
            end

            ST_WALK: begin
                if (w_step_off) begin
                    w_dir_end = 1'b1;
                end else if (w_walk_code == w_opp) begin
                    w_run_next = r_run | (MASK_LSB << w_step_cell);
                    if (w_look_off) begin
                        w_dir_end = 1'b1;
                    end else begin
                        w_ptr_next = w_step_cell;
                    end
                end else if ((w_walk_code == w_own) && (r_run != '0)) begin
                    w_acc_next = r_acc | r_run;
                    w_dir_end  = 1'b1;
                end else begin
                    w_dir_end = 1'b1;
                end

                if (w_dir_end) begin
                    w_run_next = '0;
                    w_ptr_next = r_target;
                    if (r_dir == DIR_LAST) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_dir_next = r_dir + DIR_W'(1);
                    end
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Capture of the request operands.
    always_ff @(posedge clk) begin
        // NOTE: the captured board/index/colour are deliberately left out of
        // reset; they are always reloaded on an accepted start before use.
        if (w_accept) begin
            r_board  <= curr_board;
            r_index  <= index;
            r_player <= player_black;
        end
    end

    // Walk registers and the result registers (cleared on accept, loaded on
    // entry to DONE so they are valid together with the done pulse).
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_target     <= '0;
            r_ptr        <= '0;
            r_dir        <= '0;
            r_run        <= '0;
            r_acc        <= '0;
            r_flip_mask  <= '0;
            r_legal      <= 1'b0;
            r_flip_count <= '0;
        end else begin
            r_ptr <= w_ptr_next;
            r_dir <= w_dir_next;
            r_run <= w_run_next;
            r_acc <= w_acc_next;

            if (r_state == ST_CHECK) begin
                r_target <= w_cell_num[POS_W-1:0];
            end

            if (w_accept) begin
                r_flip_mask  <= '0;
                r_legal      <= 1'b0;
                r_flip_count <= '0;
            end else if ((w_state_next == ST_DONE) && (r_state != ST_DONE)) begin
                r_flip_mask  <= w_acc_next;
                r_legal      <= (w_acc_next != '0);
                r_flip_count <= popcount(w_acc_next);
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign legal      = r_legal;
    assign flip_mask  = r_flip_mask;
    assign flip_count = r_flip_count;

endmodule

// File: doc/move_check.md
MOVE_CHECK -- requirements
Module: move_check

Interface
REQ-001 SHALL have parameter CELLS, default 64, meaning the number of board cells (8x8).
REQ-002 SHALL have parameter CELL_W, default 3, meaning bits per cell; the board width is CELLS*CELL_W (192).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to evaluate a move.
REQ-006 SHALL have port curr_board, input, 192 bits: cell c occupies bits [3c+2:3c].
REQ-007 SHALL have port index, input, 7 bits: the bit offset of the target cell (cell = index/3).
REQ-008 SHALL have port player_black, input, 1 bit: 1 = black to move, 0 = white to move.
REQ-009 SHALL have port busy, output, 1 bit: high while an evaluation is in progress.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse when the results are valid.
REQ-011 SHALL have port legal, output, 1 bit: the move captures at least one disc.
REQ-012 SHALL have port flip_mask, output, 64 bits: bit c set means cell c flips.
REQ-013 SHALL have port flip_count, output, 5 bits: the population count of flip_mask (maximum 18).

Function
REQ-014 SHALL decode each cell as: 111 = black, 110 = white, 0xx = empty; the opponent colour is the one not selected by player_black.
REQ-015 SHALL sample start only in state IDLE, capturing curr_board, index and player_black together; start while busy is ignored.
REQ-016 SHALL use the states IDLE -> CHECK -> WALK -> DONE -> IDLE.
REQ-017 SHALL hold busy high in CHECK, WALK and DONE, and low in IDLE.
REQ-018 SHALL, in CHECK, go straight to DONE with legal=0, flip_mask=0 and flip_count=0 if index>189, index mod 3 != 0, or the target cell is occupied.
REQ-019 SHALL otherwise enter WALK with the direction set to 0, in the order N, NE, E, SE, S, SW, W, NW (cell deltas -8, -7, +1, +9, +8, +7, -1, -9).
REQ-020 SHALL, in WALK, read exactly one cell per cycle at pointer+delta.
REQ-021 SHALL detect off-board moves from row/column bounds; column wrap (for example cell 7 east to cell 8) is off-board.
REQ-022 SHALL, when the WALK cell holds an opponent disc, set that cell's bit in a run mask and continue in the same direction.
REQ-023 SHALL, when the WALK cell holds an own disc and the run mask is non-zero, OR the run mask into flip_mask, then clear the run mask and advance to the next direction.
REQ-024 SHALL, when the WALK cell is empty, off-board, or own with an empty run, discard the run mask and advance to the next direction.
REQ-025 SHALL move from WALK to DONE after direction 7 completes, so the total latency from start to done is at most 2 + 8*7 = 58 cycles.
REQ-026 SHALL, in DONE, pulse done for 1 cycle, set legal = (flip_mask != 0), and make flip_count valid, then return to IDLE.
REQ-027 SHALL hold legal, flip_mask and flip_count stable from done until the next accepted start, and clear them to 0 when the next start is accepted.
REQ-028 SHALL have done and the next accepted start occur at least 1 cycle apart (back-to-back requests are accepted from IDLE).

Reset
REQ-029 SHALL, with resetn high at a clock edge, force state IDLE and clear busy, done, legal, flip_mask, flip_count, the run mask, the pointer and the direction to 0.
REQ-030 SHALL have reset take priority over start; reset during CHECK or WALK abandons the evaluation with no done pulse.

Structure
REQ-031 SHALL place the cell codes (EMPTY, BLACK=111, WHITE=110), CELL_W, CELLS, the board width, the state encoding and the direction delta table in a shared package, reversi_pkg.
REQ-032 SHALL use one sub-module, board_step, a combinational block that takes a cell and a direction and returns the next cell and an off_board flag.

Verification
REQ-033 SHALL check: opening board (27=W, 28=B, 35=B, 36=W), black, index 57 (cell 19) -> legal=1, flip_mask bit 27 only, flip_count=1.
REQ-034 SHALL check: opening board, white, index 0 (cell 0) -> done within 58 cycles, legal=0, mask=0.
REQ-035 SHALL check: target index 84 (cell 28, occupied), or index 58 -> done 2 cycles after start, legal=0.
REQ-036 SHALL check wrap: cell 7 = white, cell 8 = black, black at cell 6 -> cell 7 is not flipped and legal=0.
REQ-037 SHALL check multi-direction: black at cell 0, whites at 1, 8 and 9, blacks at 2, 16 and 18 -> mask bits {1, 8, 9}, count=3.
REQ-038 SHALL check: resetn pulsed mid-WALK -> busy=0 the next cycle, no done pulse, and a fresh start then evaluates correctly; start pulsed while busy has no effect.
